// File: rtl/tick_timer_pkg.sv
// Shared types, defaults and helpers for the tick timer arbiter.
// State encoding, parameter defaults, index-to-one-hot helper.
package tick_timer_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int CNT_W_DEF    = 8;
  localparam int PRESCALE_DEF = 10;
  localparam int MAX_NREQ     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [MAX_NREQ-1:0] idx2oh(
    input logic [2:0] idx
  );
    logic [MAX_NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tick_timer_arbiter_if.sv
// Requester-side bundle of the tick timer arbiter.
// master = requesters, slave = arbiter.
interface tick_timer_arbiter_if
  import tick_timer_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] len;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  tick;

  modport master (
    output req, len,
    input  grant, done, busy, tick
  );

  modport slave (
    input  req, len,
    output grant, done, busy, tick
  );

endinterface

// File: rtl/decade_prescaler.sv
// Free-running clk divider producing a one-cycle tick per PRESCALE cycles.
// clr has priority over en; tick only asserts while enabled.
module decade_prescaler
  import tick_timer_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // next count: clear, wrap at LAST, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/tick_timer_arbiter.sv
// Round-robin owner of one prescaled interval timer for NREQ requesters.
// Define TICK_TIMER_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module tick_timer_arbiter
  import tick_timer_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input logic                 clk,
  input logic                 rst,
  tick_timer_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [IW-1:0]    g_q, g_d;
  logic [IW-1:0]    pick;
  logic             found;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] len_g;
  logic [NREQ-1:0]  oh;
  logic             owner_req;
  logic             run;
  logic             busy;
  logic             tick_w;

  assign owner_req = bus.req[g_q];
  assign len_g     = bus.len[g_q*CNT_W +: CNT_W];
  assign run       = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);

`ifdef TICK_TIMER_ARB_FIXED_PRIO_EN

  // lowest asserted index wins
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        pick  = IW'(k);
        found = 1'b1;
      end
    end
  end

`else

  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] g_nxt;

  assign g_nxt = (int'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;

  // first asserted index scanning from rr_q upward, wrapping
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(rr_q) + k) % NREQ]) begin
        pick  = IW'((int'(rr_q) + k) % NREQ);
        found = 1'b1;
      end
    end
  end

  // pointer moves past the owner when it leaves, done or aborted
  always_comb begin
    rr_d = rr_q;
    if (state_q == ST_DONE) begin
      rr_d = g_nxt;
    end else if ((state_q == ST_GRANT || run) && !owner_req) begin
      rr_d = g_nxt;
    end
  end

  // round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

`endif

  decade_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (!run),
    .tick (tick_w)
  );

  // next state, owner and remaining ticks
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    remain_d = remain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          g_d     = pick;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          remain_d = '0;
          state_d  = ST_IDLE;
        end else begin
          remain_d = len_g;
          state_d  = (len_g == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!owner_req) begin
          remain_d = '0;
          state_d  = ST_IDLE;
        end else if (tick_w) begin
          remain_d = remain_q - 1'b1;
          if (remain_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        remain_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      g_q      <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      remain_q <= remain_d;
    end
  end

  assign oh        = NREQ'(idx2oh(3'(g_q)));
  assign bus.busy  = busy;
  assign bus.grant = busy ? oh : '0;
  assign bus.done  = (state_q == ST_DONE) ? oh : '0;
  assign bus.tick  = tick_w;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Randomized bench for tick_timer_arbiter against a schedule model.
// Model tracks owner and cycles since grant; outputs follow by arithmetic.
module tb_tick_timer_arbiter;

  localparam int NREQ  = 4;
  localparam int CNT_W = 8;
  localparam int P     = 10;
  localparam int NCYC  = 20000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tick_timer_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

  tick_timer_arbiter #(
    .NREQ     (NREQ),
    .CNT_W    (CNT_W),
    .PRESCALE (P)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_rst = 0;

  int m_own = -1;
  int m_age = 0;
  int m_len = 0;
  int m_ptr = 0;

  int lens [NREQ];
  logic [NREQ-1:0] req;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rand_len();
    if ($urandom_range(0, 63) == 0) return int'($urandom_range(200, 255));
    return int'($urandom_range(0, 4));
  endfunction

  task automatic drive();
    bus.req = req;
    for (int i = 0; i < NREQ; i++) bus.len[i*CNT_W +: CNT_W] = CNT_W'(lens[i]);
  endtask

  function automatic int pick(logic [NREQ-1:0] r);
`ifdef TICK_TIMER_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 0; k < NREQ; k++) if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
    return -1;
  endfunction

  function automatic bit in_done();
    return (m_own >= 0) && (m_age == m_len * P + 1);
  endfunction

  task automatic check_outs();
    logic [31:0] eg, ed, eb, et;
    eg = 0; ed = 0; eb = 0; et = 0;
    if (m_own >= 0) begin
      eg = 32'd1 << m_own;
      eb = 1;
      ed = in_done() ? eg : 0;
      et = (m_age >= 1 && m_age <= m_len * P && m_age % P == 0) ? 1 : 0;
    end
    check("grant", 32'(bus.grant), eg);
    check("done", 32'(bus.done), ed);
    check("busy", 32'(bus.busy), eb);
    check("tick", 32'(bus.tick), et);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_grant"}, 32'(bus.grant), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_tick"}, 32'(bus.tick), 0);
  endtask

  // advance model across one rising edge using the driven inputs
  task automatic step();
    if (m_own < 0) begin
      if (req != '0) begin
        m_own = pick(req);
        m_age = 0;
      end
    end else begin
      if (m_age == 0) m_len = lens[m_own];
      if (in_done() || !req[m_own]) begin
        m_ptr = (m_own + 1) % NREQ;
        m_own = -1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic new_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (m_own == i && in_done()) req[i] = 1'b0;
      else if (!req[i] && $urandom_range(0, 7) == 0) req[i] = 1'b1;
      else if (req[i] && $urandom_range(0, 199) == 0) req[i] = 1'b0;
      lens[i] = rand_len();
    end
  endtask

  initial begin
    req = '1;
    for (int i = 0; i < NREQ; i++) lens[i] = rand_len();
    drive();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    step();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      check_outs();
      if (m_own >= 0 && m_age >= 2 && m_age < m_len * P &&
          ($urandom_range(0, 299) == 0 || (n_rst == 0 && c > NCYC / 2))) begin
        n_rst++;
        #1 rst = 1'b0;
        #1 check_zero("async_rst");
        m_own = -1;
        m_ptr = 0;
        @(negedge clk);
        check_zero("rst_hold");
        rst = 1'b1;
        step();
      end else begin
        new_inputs();
        drive();
        step();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
